// File: rtl/edge_pattern_generator_pkg.sv
// Constants shared between the edge pattern generator and the edge detectors
// that receive its serial line.
package edge_pattern_generator_pkg;

  localparam int SEQ_MIN_WIDTH = 2;

endpackage

// File: rtl/edge_pattern_generator.sv
// Serial edge/pulse generator: turns rise/fall/pulse strobes into a registered
// line that is held stable for a minimum number of cycles after each transition.
module edge_pattern_generator
  import edge_pattern_generator_pkg::*;
#(
  parameter int width     = SEQ_MIN_WIDTH,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rise_req,
  input  logic                 fall_req,
  input  logic                 pulse_req,
  input  logic [cnt_width-1:0] pulse_len,
  output logic                 sequence_out,
  output logic                 busy,
  output logic                 req_ack,
  output logic                 req_drop
);

  localparam logic [2:0] IDLE_LOW   = 3'd0;
  localparam logic [2:0] HOLD_HIGH  = 3'd1;
  localparam logic [2:0] IDLE_HIGH  = 3'd2;
  localparam logic [2:0] PULSE_HIGH = 3'd3;
  localparam logic [2:0] HOLD_LOW   = 3'd4;

  localparam logic [cnt_width-1:0] HOLD_LEN = cnt_width'(width);
  localparam logic [cnt_width-1:0] ONE      = cnt_width'(1);

  logic [2:0]           state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic                 seq_q, seq_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic                 drop_q, drop_d;

  logic                 any_req, multi_req;
  logic                 acc_pulse, acc_rise, acc_fall, accept;
  logic [cnt_width-1:0] pulse_load;

  // Strict priority: only the top-priority request is considered; if it is not
  // applicable in the current state, everything asserted this cycle is refused.
  assign any_req   = rise_req | fall_req | pulse_req;
  assign multi_req = (rise_req & fall_req) | (rise_req & pulse_req) | (fall_req & pulse_req);
  assign acc_pulse = (state_q == IDLE_LOW) & pulse_req;
  assign acc_rise  = (state_q == IDLE_LOW) & rise_req & ~pulse_req;
  assign acc_fall  = (state_q == IDLE_HIGH) & fall_req & ~pulse_req & ~rise_req;
  assign accept    = acc_pulse | acc_rise | acc_fall;
  assign pulse_load = (pulse_len < HOLD_LEN) ? HOLD_LEN : pulse_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      seq_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
    end
  end

  // The counter holds the number of cycles left in the current state, ending at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE_LOW: begin
        if (acc_pulse) begin
          state_d = PULSE_HIGH;
          cnt_d   = pulse_load;
        end else if (acc_rise) begin
          state_d = HOLD_HIGH;
          cnt_d   = HOLD_LEN;
        end
      end
      HOLD_HIGH: begin
        if (cnt_q <= ONE) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      IDLE_HIGH: begin
        if (acc_fall) begin
          state_d = HOLD_LOW;
          cnt_d   = HOLD_LEN;
        end
      end
      PULSE_HIGH: begin
        if (cnt_q <= ONE) begin
          state_d = HOLD_LOW;
          cnt_d   = HOLD_LEN;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLD_LOW: begin
        if (cnt_q <= ONE) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    seq_d  = (state_d == HOLD_HIGH) || (state_d == IDLE_HIGH) || (state_d == PULSE_HIGH);
    busy_d = (state_d == HOLD_HIGH) || (state_d == PULSE_HIGH) || (state_d == HOLD_LOW);
    ack_d  = accept;
    drop_d = any_req & (~accept | multi_req);
  end

  assign sequence_out = seq_q;
  assign busy         = busy_q;
  assign req_ack      = ack_q;
  assign req_drop     = drop_q;

endmodule

// File: tb/tb_edge_pattern_generator.sv
// Bench for edge_pattern_generator: schedule-queue reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_edge_pattern_generator;

  localparam int W  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rise_req = 1'b0;
  logic          fall_req = 1'b0;
  logic          pulse_req = 1'b0;
  logic [CW-1:0] pulse_len = '0;
  logic          sequence_out;
  logic          busy;
  logic          req_ack;
  logic          req_drop;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  edge_pattern_generator #(.width(W), .cnt_width(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rise_req     (rise_req),
    .fall_req     (fall_req),
    .pulse_req    (pulse_req),
    .pulse_len    (pulse_len),
    .sequence_out (sequence_out),
    .busy         (busy),
    .req_ack      (req_ack),
    .req_drop     (req_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the future of the line is a queue of per-cycle levels,
  // each of which is a busy cycle; an empty queue means idle at the last level.
  bit   m_q[$];
  logic m_level = 1'b0;
  logic m_busy  = 1'b0;
  logic m_ack   = 1'b0;
  logic m_drop  = 1'b0;

  task automatic model_step(input logic r, input logic f, input logic p, input logic [CW-1:0] len);
    bit ok = 1'b0;
    int plen;
    m_ack  = 1'b0;
    m_drop = 1'b0;
    if (r | f | p) begin
      if (!m_busy) begin
        if (p) begin
          if (!m_level) begin
            ok = 1'b1;
            plen = (int'(len) < W) ? W : int'(len);
            repeat (plen) m_q.push_back(1'b1);
            repeat (W) m_q.push_back(1'b0);
          end
        end else if (r) begin
          if (!m_level) begin
            ok = 1'b1;
            repeat (W) m_q.push_back(1'b1);
          end
        end else if (m_level) begin
          ok = 1'b1;
          repeat (W) m_q.push_back(1'b0);
        end
        m_ack  = ok;
        m_drop = !ok || ((r & f) | (r & p) | (f & p));
      end else begin
        m_drop = 1'b1;
      end
    end
    if (m_q.size() > 0) begin
      m_level = m_q.pop_front();
      m_busy  = 1'b1;
    end else begin
      m_busy = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_level = 1'b0;
      m_busy  = 1'b0;
      m_ack   = 1'b0;
      m_drop  = 1'b0;
    end else begin
      model_step(rise_req, fall_req, pulse_req, pulse_len);
    end
    #1;
    if (chk_en) begin
      check("model_seq",  {31'd0, sequence_out}, {31'd0, m_level});
      check("model_busy", {31'd0, busy},         {31'd0, m_busy});
      check("model_ack",  {31'd0, req_ack},      {31'd0, m_ack});
      check("model_drop", {31'd0, req_drop},     {31'd0, m_drop});
    end
  end

  // Called at a falling edge: drives the request for one cycle and records the
  // outputs of the following n cycles (bit i = cycle n+1+i).
  task automatic trace(input logic r, input logic f, input logic p, input logic [CW-1:0] len,
                       input int n, output logic [31:0] sv, output logic [31:0] bv,
                       output logic [31:0] av, output logic [31:0] dv,
                       output int scnt, output int bcnt);
    sv = '0; bv = '0; av = '0; dv = '0; scnt = 0; bcnt = 0;
    rise_req = r; fall_req = f; pulse_req = p; pulse_len = len;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rise_req = 1'b0; fall_req = 1'b0; pulse_req = 1'b0;
      end
      if (i < 32) begin
        sv[i] = sequence_out; bv[i] = busy; av[i] = req_ack; dv[i] = req_drop;
      end
      scnt += int'(sequence_out);
      bcnt += int'(busy);
    end
  endtask

  logic [31:0] sv, bv, av, dv;
  int          scnt, bcnt;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_after_reset", {28'd0, sequence_out, busy, req_ack, req_drop}, 32'h0);
    end

    trace(1'b1, 1'b0, 1'b0, 8'd0, 3, sv, bv, av, dv, scnt, bcnt);
    check("rise_seq",  sv, 32'h7);
    check("rise_busy", bv, 32'h3);
    check("rise_ack",  av, 32'h1);
    check("rise_drop", dv, 32'h0);
    trace(1'b0, 1'b1, 1'b0, 8'd0, 3, sv, bv, av, dv, scnt, bcnt);
    check("fall_seq",  sv, 32'h0);
    check("fall_busy", bv, 32'h3);
    check("fall_ack",  av, 32'h1);

    trace(1'b1, 1'b0, 1'b0, 8'd0, 1, sv, bv, av, dv, scnt, bcnt);
    trace(1'b0, 1'b1, 1'b0, 8'd0, 2, sv, bv, av, dv, scnt, bcnt);
    check("busy_fall_drop", dv, 32'h1);
    check("busy_fall_ack",  av, 32'h0);
    check("busy_fall_seq",  sv, 32'h3);
    trace(1'b0, 1'b0, 1'b1, 8'd5, 1, sv, bv, av, dv, scnt, bcnt);
    check("pulse_in_high_drop", {av[0], dv[0], sv[0]}, 32'h3);
    trace(1'b0, 1'b1, 1'b0, 8'd0, 3, sv, bv, av, dv, scnt, bcnt);

    trace(1'b0, 1'b0, 1'b1, 8'd5, 8, sv, bv, av, dv, scnt, bcnt);
    check("pulse5_seq",  sv, 32'h1F);
    check("pulse5_busy", bv, 32'h7F);
    check("pulse5_ack",  av, 32'h1);
    trace(1'b0, 1'b0, 1'b1, 8'd0, 5, sv, bv, av, dv, scnt, bcnt);
    check("pulse0_seq",  sv, 32'h3);
    check("pulse0_busy", bv, 32'hF);

    trace(1'b1, 1'b0, 1'b1, 8'd3, 6, sv, bv, av, dv, scnt, bcnt);
    check("pulse_rise_ack",  av, 32'h1);
    check("pulse_rise_drop", dv, 32'h1);
    check("pulse_rise_seq",  sv, 32'h7);
    check("pulse_rise_busy", bv, 32'h1F);

    trace(1'b0, 1'b1, 1'b0, 8'd0, 1, sv, bv, av, dv, scnt, bcnt);
    check("fall_in_low", {av[0], dv[0], sv[0]}, 32'h2);

    trace(1'b0, 1'b0, 1'b1, 8'd255, 260, sv, bv, av, dv, scnt, bcnt);
    check("pulse255_high", scnt, 255);
    check("pulse255_busy", bcnt, 257);

    trace(1'b0, 1'b0, 1'b1, 8'd100, 30, sv, bv, av, dv, scnt, bcnt);
    check("pulse100_running", scnt, 30);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_pulse", {28'd0, sequence_out, busy, req_ack, req_drop}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    trace(1'b0, 1'b0, 1'b1, 8'd5, 8, sv, bv, av, dv, scnt, bcnt);
    check("post_rst_seq",  sv, 32'h1F);
    check("post_rst_busy", bv, 32'h7F);
    check("post_rst_ack",  av, 32'h1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rise_req = 1'b0; fall_req = 1'b0; pulse_req = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rand_async_rst", {28'd0, sequence_out, busy, req_ack, req_drop}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        rise_req  = ($urandom_range(0, 4) == 0);
        fall_req  = ($urandom_range(0, 4) == 0);
        pulse_req = ($urandom_range(0, 4) == 0);
        pulse_len = ($urandom_range(0, 15) == 0) ? 8'd255 : CW'($urandom_range(0, 7));
        @(negedge clk);
      end
    end
    rise_req = 1'b0; fall_req = 1'b0; pulse_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_pattern_generator.md
EDGE_PATTERN_GENERATOR -- requirements
Module: edge_pattern_generator

Interface
REQ-001 Parameter width, default 2: minimum number of cycles sequence_out is held stable after any transition.
REQ-002 Parameter cnt_width, default 16: width of pulse_len and the internal hold/pulse counter.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rise_req  input  1  one-cycle strobe: drive sequence_out high.
REQ-006 fall_req  input  1  one-cycle strobe: drive sequence_out low.
REQ-007 pulse_req  input  1  one-cycle strobe: emit one high pulse of pulse_len cycles.
REQ-008 pulse_len  input  cnt_width  pulse length in cycles, sampled with pulse_req.
REQ-009 sequence_out  output  1  generated serial line, registered.
REQ-010 busy  output  1  high while a hold or pulse is in progress; requests refused.
REQ-011 req_ack  output  1  one-cycle pulse: a request was accepted.
REQ-012 req_drop  output  1  one-cycle pulse: a request was refused.

Function
REQ-013 FSM states SHALL be IDLE_LOW, HOLD_HIGH, IDLE_HIGH, PULSE_HIGH, HOLD_LOW; all outputs registered.
REQ-014 Request present in cycle n SHALL produce the sequence_out change and req_ack/req_drop in cycle n+1 (one-cycle latency).
REQ-015 Simultaneous requests: priority pulse_req > rise_req > fall_req; the winner is handled, and any other asserted request raises req_drop in the same cycle as req_ack.
REQ-016 IDLE_LOW + rise_req -> sequence_out=1, req_ack, go HOLD_HIGH.
REQ-017 HOLD_HIGH SHALL last so that sequence_out is high exactly width cycles (n+1..n+width) with busy=1, then go IDLE_HIGH.
REQ-018 IDLE_HIGH + fall_req -> sequence_out=0, req_ack, go HOLD_LOW; HOLD_LOW holds low width cycles with busy=1, then go IDLE_LOW.
REQ-019 IDLE_LOW + pulse_req -> sequence_out=1, req_ack, load L = max(pulse_len, width) (pulse_len=0 treated as width), go PULSE_HIGH.
REQ-020 PULSE_HIGH: sequence_out high exactly L cycles (n+1..n+L), then low from n+L+1 entering HOLD_LOW; busy=1 from n+1 through n+L+width.
REQ-021 Redundant requests (rise_req in IDLE_HIGH, fall_req or pulse_req in IDLE_LOW/IDLE_HIGH where not applicable: pulse_req in IDLE_HIGH) SHALL raise req_drop with no line change.
REQ-022 Any request while busy=1 SHALL raise req_drop and not alter state, counter or sequence_out.
REQ-023 busy SHALL be 1 in HOLD_HIGH, PULSE_HIGH, HOLD_LOW and 0 in IDLE_LOW/IDLE_HIGH.
REQ-024 Counter SHALL count down from loaded value to 1 without wrap; pulse_len = 2^cnt_width-1 SHALL produce exactly that many high cycles.
REQ-025 req_ack and req_drop SHALL never both be asserted from a single request.

Reset
REQ-026 rst_n low SHALL immediately force IDLE_LOW, sequence_out=0, busy=0, req_ack=0, req_drop=0, counter=0, regardless of state (including mid-pulse).
REQ-027 First request SHALL be accepted in the first cycle after rst_n deasserts.

Structure
REQ-028 State codes SHALL be module-local constants; shared package holds only the default minimum-hold constant (SEQ_MIN_WIDTH = 2) shared with receiving edge detectors.
REQ-029 Single module, no sub-modules; one FSM and one cnt_width down-counter.

Verification (width=2, cnt_width=8)
REQ-030 Reset release, no stimulus -> sequence_out=0, busy=0, req_ack=0, req_drop=0 for 20 cycles.
REQ-031 rise_req cycle 5 -> sequence_out=1 and req_ack in cycle 6, busy cycles 6-7; fall_req cycle 8 -> sequence_out=0 cycle 9, busy 9-10.
REQ-032 rise_req cycle 5, fall_req cycle 6 -> req_drop cycle 7, sequence_out stays 1.
REQ-033 pulse_req, pulse_len=5, cycle 10 -> sequence_out high 11-15, low from 16, busy 11-17; pulse_len=0 -> high exactly 2 cycles.
REQ-034 pulse_req+rise_req both in cycle 10 -> pulse executed, req_ack and req_drop in cycle 11.
REQ-035 rst_n low in middle of pulse_len=100 pulse -> sequence_out=0, busy=0 without waiting for clk; next pulse_req after release behaves per REQ-020.
